// File: rtl/vec_inst_queue_pkg.sv
// Shared definitions for the vector instruction queue: data-path width,
// default queue depth and the issue-FSM state encoding.
package vec_inst_queue_pkg;

  // Scalar core data-path width (instruction word and operand width).
  localparam int unsigned VIQ_XLEN  = 32;

  // Default number of queue entries (power of two, 2..16).
  localparam int unsigned VIQ_DEPTH = 4;

  // Issue FSM toward the vector processor.
  typedef enum logic [1:0] {
    ISSUE_IDLE     = 2'd0,
    ISSUE_OFFER    = 2'd1,
    ISSUE_WAIT_ACK = 2'd2
  } issue_state_e;

endpackage : vec_inst_queue_pkg

// File: rtl/vec_inst_fifo.sv
// Storage, read/write pointers and occupancy count for the vector
// instruction queue.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset (pointers and count only)
//   push_i   write request; ignored while full or during flush
//   pop_i    read request; ignored while empty or during flush
//   flush_i  clear pointers and count; wins over a same-cycle push/pop
//   data_i   entry to write at the write pointer
//   data_o   entry at the read pointer (undefined while empty)
//   count_o  current occupancy, 0..DEPTH
//   full_o   occupancy equals DEPTH
module vec_inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_i && !full && !flush_i;
  assign pop_ok  = pop_i && !empty && !flush_i;

  // Pointer/count next state; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full;

endmodule : vec_inst_fifo

// File: rtl/vec_inst_queue.sv
// Decoupling queue between the scalar core and the vector processor.
// Instructions with their scalar operands are buffered in a FIFO and issued
// one at a time; a new instruction is offered only after the previous one
// has been acknowledged as complete.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   sp_valid            scalar core presents an instruction
//   sp_instruction      instruction word
//   sp_rs1_data/rs2     scalar operands
//   q_ready             queue not full
//   flush               discard all queued, un-issued entries
//   inst_valid          head entry offered to the vector processor
//   instruction/rs1/rs2 head entry fields (zero when not offered)
//   vec_pro_ready       vector processor accepts the offer
//   vec_pro_ack         vector processor completed the in-flight instruction
//   count               queue occupancy
//   busy                an instruction is in flight awaiting ack
module vec_inst_queue
  import vec_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = VIQ_DEPTH,
  parameter int unsigned XLEN  = VIQ_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sp_valid,
  input  logic [XLEN-1:0]        sp_instruction,
  input  logic [XLEN-1:0]        sp_rs1_data,
  input  logic [XLEN-1:0]        sp_rs2_data,
  output logic                   q_ready,
  input  logic                   flush,
  output logic                   inst_valid,
  output logic [XLEN-1:0]        instruction,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  input  logic                   vec_pro_ready,
  input  logic                   vec_pro_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 3 * XLEN;

  issue_state_e       state_q, state_d;
  logic               pop;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] head;
  logic               offering;

  // Entry layout: {instruction, rs1, rs2}.
  vec_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (sp_valid),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({sp_instruction, sp_rs1_data, sp_rs2_data}),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ISSUE_IDLE;
    else        state_q <= state_d;
  end

  // Issue FSM next state; acks outside WAIT_ACK fall through unused.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ISSUE_IDLE: begin
        if (!flush && (fifo_count != '0)) state_d = ISSUE_OFFER;
      end
      ISSUE_OFFER: begin
        if (flush) begin
          state_d = ISSUE_IDLE;
        end else if (vec_pro_ready) begin
          pop     = 1'b1;
          state_d = ISSUE_WAIT_ACK;
        end
      end
      ISSUE_WAIT_ACK: begin
        // Flush does not abort the in-flight instruction, only what is queued.
        if (vec_pro_ack) begin
          if (!flush && (fifo_count != '0)) state_d = ISSUE_OFFER;
          else                              state_d = ISSUE_IDLE;
        end
      end
      default: state_d = ISSUE_IDLE;
    endcase
  end

  // Outputs decode directly from registered state/count.
  assign offering    = (state_q == ISSUE_OFFER);
  assign inst_valid  = offering;
  assign busy        = (state_q == ISSUE_WAIT_ACK);
  assign q_ready     = !fifo_full;
  assign count       = fifo_count;
  assign instruction = offering ? head[3*XLEN-1 -: XLEN] : '0;
  assign rs1_data    = offering ? head[2*XLEN-1 -: XLEN] : '0;
  assign rs2_data    = offering ? head[XLEN-1   -: XLEN] : '0;

endmodule : vec_inst_queue

// File: tb/tb_vec_inst_queue.sv
// Directed self-checking bench for vec_inst_queue (DEPTH=4, XLEN=32).
module tb_vec_inst_queue;

  logic        clk;
  logic        reset;
  logic        sp_valid;
  logic [31:0] sp_instruction;
  logic [31:0] sp_rs1_data;
  logic [31:0] sp_rs2_data;
  logic        q_ready;
  logic        flush;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        vec_pro_ready;
  logic        vec_pro_ack;
  logic [2:0]  count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] expq[$];
  logic [31:0] e;

  vec_inst_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .sp_valid       (sp_valid),
    .sp_instruction (sp_instruction),
    .sp_rs1_data    (sp_rs1_data),
    .sp_rs2_data    (sp_rs2_data),
    .q_ready        (q_ready),
    .flush          (flush),
    .inst_valid     (inst_valid),
    .instruction    (instruction),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .vec_pro_ready  (vec_pro_ready),
    .vec_pro_ack    (vec_pro_ack),
    .count          (count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    sp_valid = 1'b1; sp_instruction = ins; sp_rs1_data = a; sp_rs2_data = b;
    tick();
    sp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (q_ready !== 1'b1) begin bad++; $display("FAIL rst_q_ready got=%b exp=1", q_ready); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instruction got=%h exp=0", instruction); end
  endtask

  task automatic test_latency();
    do_reset();
    push(32'h0000_0057, 32'd5, 32'd7);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL lat_edge1_valid got=%b exp=0", inst_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL lat_edge1_count got=%0d exp=1", count); end
    tick();
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL lat_edge2_valid got=%b exp=1", inst_valid); end
    total++; if (instruction !== 32'h57) begin bad++; $display("FAIL lat_instr got=%h exp=57", instruction); end
    total++; if (rs1_data !== 32'd5) begin bad++; $display("FAIL lat_rs1 got=%h exp=5", rs1_data); end
    total++; if (rs2_data !== 32'd7) begin bad++; $display("FAIL lat_rs2 got=%h exp=7", rs2_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", count); end
    vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b exp=1", busy); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL lat_wait_valid got=%b exp=0", inst_valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL lat_wait_instr got=%h exp=0", instruction); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL lat_pop_count got=%0d exp=0", count); end
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_ack_busy got=%b exp=0", busy); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL lat_idle_valid got=%b exp=0", inst_valid); end
  endtask

  task automatic test_full();
    logic qr_exp;
    logic [2:0] cnt_exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(32'h100 + 32'(i), 32'(i), 32'(i));
      qr_exp  = (i < 3);
      cnt_exp = (i < 4) ? 3'(i + 1) : 3'd4;
      total++; if (q_ready !== qr_exp) begin bad++; $display("FAIL full_q_ready[%0d] got=%b exp=%b", i, q_ready, qr_exp); end
      total++; if (count !== cnt_exp) begin bad++; $display("FAIL full_count[%0d] got=%0d exp=%0d", i, count, cnt_exp); end
    end
    // Drain: the fifth push (0x104) must not appear.
    for (int i = 0; i < 4; i++) begin
      e = 32'h100 + 32'(i);
      total++; if (inst_valid !== 1'b1 || instruction !== e) begin bad++; $display("FAIL full_drain[%0d] got=%b/%h exp=1/%h", i, inst_valid, instruction, e); end
      vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
      vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    end
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0d/%b exp=0/0", count, inst_valid); end
  endtask

  task automatic test_ack_delay();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), 32'(i), 32'(i + 10));
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ack_fill_count got=%0d exp=4", count); end
    total++; if (instruction !== 32'h200) begin bad++; $display("FAIL ack_first got=%h exp=200", instruction); end
    vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (busy !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL ack_busy[%0d] got=%b/%b exp=1/0", c, busy, inst_valid); end
      if (c < 2) tick();
    end
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    total++; if (busy !== 1'b0 || inst_valid !== 1'b1) begin bad++; $display("FAIL ack_reoffer got=%b/%b exp=0/1", busy, inst_valid); end
    total++; if (instruction !== 32'h201 || rs1_data !== 32'd1 || rs2_data !== 32'd11) begin bad++; $display("FAIL ack_second got=%h/%h/%h exp=201/1/b", instruction, rs1_data, rs2_data); end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL ack_count got=%0d exp=3", count); end
    // Stray ack while offering is ignored; offer stays stable.
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    total++; if (inst_valid !== 1'b1 || instruction !== 32'h201 || count !== 3'd3) begin bad++; $display("FAIL ack_stray got=%b/%h/%0d exp=1/201/3", inst_valid, instruction, count); end
    for (int i = 1; i < 4; i++) begin
      e = 32'h200 + 32'(i);
      total++; if (inst_valid !== 1'b1 || instruction !== e) begin bad++; $display("FAIL ack_order[%0d] got=%b/%h exp=1/%h", i, inst_valid, instruction, e); end
      vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
      vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      push(32'h300 + 32'(i), 32'h0, 32'h0);
      expq.push_back(32'h300 + 32'(i));
    end
    total++; if (q_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", q_ready); end
    // Push while full on the accept edge: pop happens, push is dropped.
    e = expq.pop_front();
    total++; if (instruction !== e) begin bad++; $display("FAIL b2b_head got=%h exp=%h", instruction, e); end
    sp_valid = 1'b1; sp_instruction = 32'h3FF; vec_pro_ready = 1'b1;
    tick();
    sp_valid = 1'b0; vec_pro_ready = 1'b0;
    total++; if (count !== 3'd3 || q_ready !== 1'b1) begin bad++; $display("FAIL b2b_drop got=%0d/%b exp=3/1", count, q_ready); end
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    // Push and accept on the same edge, ten times, wrapping the pointers.
    for (int k = 0; k < 10; k++) begin
      e = expq.pop_front();
      total++; if (inst_valid !== 1'b1 || instruction !== e) begin bad++; $display("FAIL b2b_order[%0d] got=%b/%h exp=1/%h", k, inst_valid, instruction, e); end
      sp_valid = 1'b1; sp_instruction = 32'h400 + 32'(k); vec_pro_ready = 1'b1;
      expq.push_back(32'h400 + 32'(k));
      tick();
      sp_valid = 1'b0; vec_pro_ready = 1'b0;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=3", k, count); end
      vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      e = expq.pop_front();
      total++; if (inst_valid !== 1'b1 || instruction !== e) begin bad++; $display("FAIL b2b_tail[%0d] got=%b/%h exp=1/%h", k, inst_valid, instruction, e); end
      vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
      vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    end
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0d/%b exp=0/0", count, inst_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(i), 32'h0, 32'h0);
    total++; if (inst_valid !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL fl_pre got=%b/%0d exp=1/3", inst_valid, count); end
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL fl_offer got=%0d/%b exp=0/0", count, inst_valid); end
    total++; if (instruction !== 32'h0 || q_ready !== 1'b1) begin bad++; $display("FAIL fl_fields got=%h/%b exp=0/1", instruction, q_ready); end
    // Flush wins over a same-cycle push.
    flush = 1'b1; sp_valid = 1'b1; sp_instruction = 32'h5AA; tick(); flush = 1'b0; sp_valid = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fl_push got=%0d exp=0", count); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_idle got=%b exp=0", inst_valid); end
    // Flush in WAIT_ACK keeps busy until ack.
    push(32'h600, 32'h0, 32'h0);
    push(32'h601, 32'h0, 32'h0);
    total++; if (inst_valid !== 1'b1 || instruction !== 32'h600) begin bad++; $display("FAIL fl_w_offer got=%b/%h exp=1/600", inst_valid, instruction); end
    vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (busy !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL fl_w_busy got=%b/%0d exp=1/0", busy, count); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fl_w_hold got=%b exp=1", busy); end
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    total++; if (busy !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL fl_w_ack got=%b/%b exp=0/0", busy, inst_valid); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_w_idle got=%b exp=0", inst_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(i), 32'h0, 32'h0);
    vec_pro_ready = 1'b1; tick(); vec_pro_ready = 1'b0;
    total++; if (busy !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL rm_pre got=%b/%0d exp=1/2", busy, count); end
    reset = 1'b0; tick(); reset = 1'b1;
    total++; if (count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL rm_cleared got=%0d/%b exp=0/0", count, busy); end
    total++; if (inst_valid !== 1'b0 || q_ready !== 1'b1) begin bad++; $display("FAIL rm_flags got=%b/%b exp=0/1", inst_valid, q_ready); end
    vec_pro_ack = 1'b1; tick(); vec_pro_ack = 1'b0;
    total++; if (busy !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL rm_late_ack got=%b/%b/%0d exp=0/0/0", busy, inst_valid, count); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b exp=0", inst_valid); end
  endtask

  initial begin
    reset = 1'b0; sp_valid = 1'b0; sp_instruction = '0; sp_rs1_data = '0; sp_rs2_data = '0;
    flush = 1'b0; vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
    test_reset();
    test_latency();
    test_full();
    test_ack_delay();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_vec_inst_queue
